// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one uart transmitter between NREQ
// byte-stream requesters, with an idle watchdog and a one-entry output register.
module uart_tx_arbiter #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned IDLE_TIMEOUT = 1200
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic [NREQ-1:0]   grant,
  output logic              timeout
);

  localparam int unsigned   IW        = $clog2(NREQ);
  localparam int unsigned   CW        = $clog2(IDLE_TIMEOUT) + 1;
  localparam logic [CW-1:0] WD_LAST   = CW'(IDLE_TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_INIT = IW'(NREQ - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [IW-1:0] owner;
  logic [IW-1:0] last_owner;
  logic [IW-1:0] pick;
  logic          found;
  logic [IW:0]   cand;
  logic [CW-1:0] wd;
  logic          slot_free;
  logic          take;

  // The output register can take a byte when empty or draining this cycle.
  assign slot_free = !tx_valid || tx_ready;
  assign take      = (state == BUSY) && req_valid[owner] && slot_free;

  always_comb begin
    req_ready = '0;
    if (state == BUSY && slot_free) req_ready[owner] = 1'b1;
  end

  // Scan last_owner+1, last_owner+2, ... (mod NREQ); first requester found wins.
  always_comb begin
    pick  = last_owner;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = {1'b0, last_owner} + (IW+1)'(i);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (!found && req_valid[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= LAST_INIT;
      wd         <= '0;
      grant      <= '0;
      timeout    <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
    end else begin
      timeout <= 1'b0;

      if (take) begin
        tx_valid <= 1'b1;
        tx_data  <= req_data[8*owner +: 8];
      end else if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          wd <= '0;
          if (found) begin
            grant <= NREQ'(1) << pick;
            owner <= pick;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (take && req_last[owner]) begin
            state      <= IDLE;
            last_owner <= owner;
            grant      <= '0;
            wd         <= '0;
          end else if (req_valid[owner]) begin
            wd <= '0;
          end else if (wd == WD_LAST) begin
            state      <= IDLE;
            last_owner <= owner;
            grant      <= '0;
            timeout    <= 1'b1;
            wd         <= '0;
          end else if (wd != '1) begin
            wd <= wd + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: four requesters fed from per-requester
// packet queues, uart bytes and grant starts logged and compared to fixed tables.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        resetn;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [3:0]  grant;
  logic        timeout;

  int          n_cmp = 0;
  int          n_bad = 0;

  logic [8:0]  q[4][$];   // {last, data} per requester
  logic [7:0]  seen[$];
  logic [7:0]  exp_q[$];
  logic [3:0]  glog[$];
  logic [3:0]  exp_g[$];
  logic [3:0]  prev_grant;

  uart_tx_arbiter #(.NREQ(4), .IDLE_TIMEOUT(16)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .grant     (grant),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, wanted %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (q[i].size() > 0) begin
        req_valid[i]      = 1'b1;
        req_data[8*i +: 8] = q[i][0][7:0];
        req_last[i]       = q[i][0][8];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]       = 1'b0;
      end
    end
  endtask

  // Handshakes are sampled at the negedge, inputs refreshed 1 after the posedge.
  task automatic tick();
    logic [3:0] fire;
    @(negedge clk);
    fire = req_valid & req_ready;
    if (tx_valid && tx_ready) seen.push_back(tx_data);
    if (grant != 4'b0 && prev_grant == 4'b0) glog.push_back(grant);
    prev_grant = grant;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (fire[i]) void'(q[i].pop_front());
    drive();
    #1;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) q[i].delete();
    seen.delete();
    glog.delete();
    prev_grant = 4'b0;
    tx_ready   = 1'b1;
    drive();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_all();
    @(posedge clk);
    #2;
    resetn = 1'b1;
  endtask

  task automatic expect_seen(input string tag, input int budget);
    int cyc = 0;
    while (seen.size() < exp_q.size() && cyc < budget) begin
      tick();
      cyc++;
    end
    check({tag, "_count"}, 32'(seen.size()), 32'(exp_q.size()));
    for (int j = 0; j < exp_q.size(); j++)
      if (j < seen.size()) check($sformatf("%s_byte%0d", tag, j), 32'(seen[j]), 32'(exp_q[j]));
  endtask

  initial begin
    resetn    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    clear_all();
    #3;
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #2;
    resetn = 1'b1;

    // Single byte from requester 1
    q[1].push_back({1'b1, 8'h42});
    drive();
    tick();
    check("t1_grant", 32'(grant), 32'h2);
    check("t1_ready", 32'(req_ready), 32'h2);
    check("t1_txv0", 32'(tx_valid), 32'h0);
    tick();
    check("t1_txv1", 32'(tx_valid), 32'h1);
    check("t1_txd", 32'(tx_data), 32'h42);
    check("t1_grant_rel", 32'(grant), 32'h0);
    tick();
    check("t1_txv_done", 32'(tx_valid), 32'h0);
    check("t1_grant_idle", 32'(grant), 32'h0);
    exp_q = '{8'h42};
    expect_seen("t1", 2);

    // Two 3-byte packets from requesters 0 and 2, no interleaving
    do_reset();
    q[0] = '{9'h001, 9'h002, 9'h103};
    q[2] = '{9'h0A0, 9'h0A1, 9'h1A2};
    drive();
    tick();
    check("t2_first_grant", 32'(grant), 32'h1);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'hA0, 8'hA1, 8'hA2};
    expect_seen("t2", 40);
    exp_g = '{4'h1, 4'h4};
    check("t2_glog_n", 32'(glog.size()), 32'(exp_g.size()));
    for (int j = 0; j < exp_g.size(); j++)
      if (j < glog.size()) check($sformatf("t2_glog%0d", j), 32'(glog[j]), 32'(exp_g[j]));

    // All four requesters streaming single-byte packets
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q[i].push_back({1'b1, 8'(8'h10 + i)});
      q[i].push_back({1'b1, 8'(8'h20 + i)});
    end
    drive();
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23};
    expect_seen("t3", 60);
    exp_g = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    check("t3_glog_n", 32'(glog.size()), 32'(exp_g.size()));
    for (int j = 0; j < exp_g.size(); j++)
      if (j < glog.size()) check($sformatf("t3_glog%0d", j), 32'(glog[j]), 32'(exp_g[j]));

    // uart stalled 50 cycles with a byte held in the output register
    do_reset();
    tx_ready = 1'b0;
    q[1] = '{9'h055, 9'h166};
    drive();
    tick();
    tick();
    check("t4_txv", 32'(tx_valid), 32'h1);
    for (int c = 0; c < 50; c++) begin
      tick();
      check($sformatf("t4_hold_data%0d", c), 32'(tx_data), 32'h55);
      check($sformatf("t4_hold_ready%0d", c), 32'(req_ready), 32'h0);
    end
    check("t4_nothing_sent", 32'(seen.size()), 32'h0);
    tx_ready = 1'b1;
    exp_q = '{8'h55, 8'h66};
    expect_seen("t4", 10);

    // Watchdog: owner 3 goes quiet after one non-last byte
    do_reset();
    q[3].push_back({1'b0, 8'h77});
    drive();
    tick();
    check("t5_grant3", 32'(grant), 32'h8);
    tick();
    check("t5_valid_low", 32'(req_valid[3]), 32'h0);
    q[0].push_back({1'b1, 8'h88});
    drive();
    for (int k = 1; k < 16; k++) begin
      tick();
      check($sformatf("t5_no_to%0d", k), 32'(timeout), 32'h0);
      check($sformatf("t5_held%0d", k), 32'(grant), 32'h8);
    end
    tick();
    check("t5_timeout", 32'(timeout), 32'h1);
    check("t5_grant_rel", 32'(grant), 32'h0);
    tick();
    check("t5_timeout_end", 32'(timeout), 32'h0);
    check("t5_grant0", 32'(grant), 32'h1);
    exp_q = '{8'h77, 8'h88};
    expect_seen("t5", 10);

    // Asynchronous reset mid-packet
    do_reset();
    tx_ready = 1'b0;
    q[2] = '{9'h031, 9'h132};
    drive();
    tick();
    check("t6_grant2", 32'(grant), 32'h4);
    tick();
    check("t6_txv", 32'(tx_valid), 32'h1);
    q[0].push_back({1'b1, 8'h05});
    drive();
    resetn = 1'b0;
    #1;
    check("t6_async_txv", 32'(tx_valid), 32'h0);
    check("t6_async_grant", 32'(grant), 32'h0);
    check("t6_async_ready", 32'(req_ready), 32'h0);
    #1;
    resetn     = 1'b1;
    tx_ready   = 1'b1;
    seen.delete();
    prev_grant = 4'b0;
    tick();
    check("t6_regrant0", 32'(grant), 32'h1);
    exp_q = '{8'h05, 8'h32};
    expect_seen("t6", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
